audio_packet_scheduler: RTL and testbench

- Parametrised successor to the data-island packet chooser.
- Buffers pixel-domain audio samples in a configurable FIFO and packs them into Audio Sample packets, layout 0 (2 ch, up to 4 samples per packet) or layout 1 (8 ch, 1 sample per packet).
- Arbitrates every data-island slot between ACR, audio, a configurable list of InfoFrames and Null.
- Drives the packet type and audio payload consumed by the packet assembler; audio CDC is done upstream.

---
 rtl/hdmi_packet_pkg.sv | 16 +
 rtl/audio_sample_fifo.sv | 58 +++++
 rtl/audio_packet_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_audio_packet_scheduler.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/hdmi_packet_pkg.sv
// Shared packet-type constants and helpers for the HDMI data-island packet path.
package hdmi_packet_pkg;

    typedef logic [7:0] pkt_type_t;

    localparam pkt_type_t PKT_NULL  = 8'h00;
    localparam pkt_type_t PKT_ACR   = 8'h01;
    localparam pkt_type_t PKT_AUDIO = 8'h02;

    localparam int IEC_FRAMES = 192;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// Synchronous sample FIFO with occupancy count, a peek window of the oldest
// NPEEK entries and a multi-entry pop (1..NPEEK) in a single cycle.
module audio_sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int NPEEK = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            push_data_i,
    input  logic                        pop_i,
    input  logic [2:0]                  pop_num_i,
    output logic [CW-1:0]               count_o,
    output logic                        full_o,
    output logic [NPEEK-1:0][WIDTH-1:0] peek_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign push_ok = push_i && !full_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = pop_i ? rd_ptr_q + AW'(pop_num_i) : rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - (pop_i ? CW'(pop_num_i) : CW'(0));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only visible through count-qualified peeks.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

    for (genvar i = 0; i < NPEEK; i++) begin : g_peek
        assign peek_o[i] = mem_q[rd_ptr_q + AW'(i)];
    end

endmodule

// File: rtl/audio_packet_scheduler.sv
// Data-island slot arbiter: ACR > audio > (flush) > InfoFrames > Null, with audio FIFO.
// Optional partial-packet flush compiled in with `define HDMI_AUDIO_FLUSH_EN.
module audio_packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter int AUDIO_BIT_WIDTH = 16,
    parameter int CHANNELS        = 2,
    parameter int FIFO_DEPTH      = 8,
    parameter int NUM_INFOFRAMES  = 3,
    parameter logic [NUM_INFOFRAMES*8-1:0] INFOFRAME_TYPES = {8'h84, 8'h82, 8'h83},
    parameter int FLUSH_SLOTS     = 2
) (
    input  logic                                clk_pixel,
    input  logic                                reset,
    input  logic                                video_field_end,
    input  logic                                packet_enable,
    input  logic [4:0]                          packet_pixel_counter,
    input  logic                                acr_request,
    input  logic                                sample_valid,
    input  logic [CHANNELS*AUDIO_BIT_WIDTH-1:0] sample_word,
    output logic                                sample_ready,
    output logic [7:0]                          packet_type,
    output logic [8*AUDIO_BIT_WIDTH-1:0]        sample_payload,
    output logic [3:0]                          sample_present,
    output logic                                sample_layout,
    output logic [7:0]                          frame_counter,
    output logic                                sample_dropped
);

    localparam int SW  = CHANNELS * AUDIO_BIT_WIDTH;
    localparam int PW  = 8 * AUDIO_BIT_WIDTH;
    localparam int SPP = (CHANNELS == 8) ? 1 : 4;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;

    if ((CHANNELS != 2 && CHANNELS != 8) || AUDIO_BIT_WIDTH < 16 || AUDIO_BIT_WIDTH > 24 ||
        FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        NUM_INFOFRAMES < 1 || NUM_INFOFRAMES > 8 || FLUSH_SLOTS < 1) begin : g_bad_cfg
        $error("audio_packet_scheduler: illegal parameter combination");
    end

    logic [CW-1:0]           fifo_cnt;
    logic                    fifo_full;
    logic [SPP-1:0][SW-1:0]  peek;
    logic                    decide, audio_full, send_flush, send_audio, pop;
    logic [2:0]              pop_num;
    logic [PW-1:0]           aud_payload;
    logic [3:0]              aud_present;
    logic                    if_hit;
    logic [NUM_INFOFRAMES-1:0] if_sel;
    pkt_type_t               if_type;

    pkt_type_t               ptype_q, ptype_d;
    logic [PW-1:0]           payload_q, payload_d;
    logic [3:0]              present_q, present_d;
    logic                    acr_pending_q, acr_pending_d;
    logic [NUM_INFOFRAMES-1:0] if_sent_q, if_sent_d;
    logic [7:0]              frame_q, frame_d;
    logic                    dropped_q, dropped_d;
    logic [8:0]              frame_sum;

    audio_sample_fifo #(.WIDTH(SW), .DEPTH(FIFO_DEPTH), .NPEEK(SPP)) u_fifo (
        .clk_i       (clk_pixel),
        .rst_i       (reset),
        .push_i      (sample_valid && !fifo_full),
        .push_data_i (sample_word),
        .pop_i       (pop),
        .pop_num_i   (pop_num),
        .count_o     (fifo_cnt),
        .full_o      (fifo_full),
        .peek_o      (peek)
    );

    assign decide     = packet_enable && !video_field_end;
    assign audio_full = fifo_cnt >= CW'(SPP);

`ifdef HDMI_AUDIO_FLUSH_EN
    localparam int AGEW = $clog2(FLUSH_SLOTS + 1);
    logic [AGEW-1:0] flush_age_q, flush_age_d;
    logic            partial;

    assign partial    = (fifo_cnt != '0) && (fifo_cnt < CW'(4));
    assign send_flush = (CHANNELS == 2) && partial && (flush_age_q >= AGEW'(FLUSH_SLOTS));

    always_comb begin
        flush_age_d = flush_age_q;
        if (fifo_cnt == '0) begin
            flush_age_d = '0;
        end else if (decide) begin
            if (!acr_pending_q && (audio_full || send_flush))
                flush_age_d = '0;
            else if (partial && flush_age_q < AGEW'(FLUSH_SLOTS))
                flush_age_d = flush_age_q + AGEW'(1);
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) flush_age_q <= '0;
        else       flush_age_q <= flush_age_d;
    end
`else
    assign send_flush = 1'b0;
`endif

    assign send_audio = !acr_pending_q && (audio_full || send_flush);
    assign pop        = decide && send_audio;

    always_comb begin
        pop_num = 3'd0;
        if (audio_full)      pop_num = 3'(SPP);
        else if (send_flush) pop_num = fifo_cnt[2:0];
    end

    if (CHANNELS == 8) begin : g_layout1
        // One 8-channel sample: channel pair n already sits at words 2n/2n+1.
        assign aud_payload = peek[0];
        assign aud_present = 4'b1111;
    end else begin : g_layout0
        always_comb begin
            aud_payload = '0;
            aud_present = '0;
            for (int n = 0; n < 4; n++) begin
                if (3'(n) < pop_num) begin
                    aud_payload[n*SW +: SW] = peek[n];
                    aud_present[n]          = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if_hit  = 1'b0;
        if_sel  = '0;
        if_type = PKT_NULL;
        for (int i = NUM_INFOFRAMES - 1; i >= 0; i--) begin
            if (!if_sent_q[i]) begin
                if_hit    = 1'b1;
                if_sel    = '0;
                if_sel[i] = 1'b1;
                if_type   = INFOFRAME_TYPES[(NUM_INFOFRAMES-1-i)*8 +: 8];
            end
        end
    end

    always_comb begin
        ptype_d       = ptype_q;
        payload_d     = payload_q;
        present_d     = present_q;
        acr_pending_d = acr_pending_q | acr_request;
        if_sent_d     = video_field_end ? '0 : if_sent_q;
        dropped_d     = dropped_q | (sample_valid && fifo_full);

        if (packet_enable) begin
            ptype_d   = PKT_NULL;
            payload_d = '0;
            present_d = '0;
            if (decide) begin
                if (acr_pending_q) begin
                    // A request landing on the ACR slot is merged into this one.
                    ptype_d       = PKT_ACR;
                    acr_pending_d = 1'b0;
                end else if (send_audio) begin
                    ptype_d   = PKT_AUDIO;
                    payload_d = aud_payload;
                    present_d = aud_present;
                end else if (if_hit) begin
                    ptype_d   = if_type;
                    if_sent_d = if_sent_q | if_sel;
                end
            end
        end

        frame_sum = {1'b0, frame_q};
        if (packet_pixel_counter == 5'd31 && ptype_q == PKT_AUDIO)
            frame_sum = frame_sum + ((CHANNELS == 8) ? 9'd1 : 9'(popcount4(present_q)));
        frame_d = (frame_sum >= 9'(IEC_FRAMES)) ? 8'(frame_sum - 9'(IEC_FRAMES)) : frame_sum[7:0];
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            ptype_q       <= PKT_NULL;
            payload_q     <= '0;
            present_q     <= '0;
            acr_pending_q <= 1'b0;
            if_sent_q     <= '0;
            frame_q       <= '0;
            dropped_q     <= 1'b0;
        end else begin
            ptype_q       <= ptype_d;
            payload_q     <= payload_d;
            present_q     <= present_d;
            acr_pending_q <= acr_pending_d;
            if_sent_q     <= if_sent_d;
            frame_q       <= frame_d;
            dropped_q     <= dropped_d;
        end
    end

    assign sample_ready   = !fifo_full;
    assign packet_type    = ptype_q;
    assign sample_payload = payload_q;
    assign sample_present = present_q;
    assign sample_layout  = (CHANNELS == 8);
    assign frame_counter  = frame_q;
    assign sample_dropped = dropped_q;

endmodule

// File: tb/tb_audio_packet_scheduler.sv
// Directed bench for audio_packet_scheduler (layout 0, 4-entry FIFO); flush
// checks follow HDMI_AUDIO_FLUSH_EN.
module tb_audio_packet_scheduler;

    logic         clk_pixel = 1'b0;
    logic         reset;
    logic         video_field_end, packet_enable, acr_request, sample_valid;
    logic [4:0]   packet_pixel_counter;
    logic [31:0]  sample_word;
    logic         sample_ready, sample_layout, sample_dropped;
    logic [7:0]   packet_type, frame_counter;
    logic [127:0] sample_payload;
    logic [3:0]   sample_present;

    int checks = 0;
    int errors = 0;

    audio_packet_scheduler #(
        .AUDIO_BIT_WIDTH(16), .CHANNELS(2), .FIFO_DEPTH(4),
        .NUM_INFOFRAMES(3), .INFOFRAME_TYPES({8'h84, 8'h82, 8'h83}), .FLUSH_SLOTS(2)
    ) dut (
        .clk_pixel            (clk_pixel),
        .reset                (reset),
        .video_field_end      (video_field_end),
        .packet_enable        (packet_enable),
        .packet_pixel_counter (packet_pixel_counter),
        .acr_request          (acr_request),
        .sample_valid         (sample_valid),
        .sample_word          (sample_word),
        .sample_ready         (sample_ready),
        .packet_type          (packet_type),
        .sample_payload       (sample_payload),
        .sample_present       (sample_present),
        .sample_layout        (sample_layout),
        .frame_counter        (frame_counter),
        .sample_dropped       (sample_dropped)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end on a negedge.
    task automatic push(input logic [31:0] d);
        sample_valid = 1'b1;
        sample_word  = d;
        @(negedge clk_pixel);
        sample_valid = 1'b0;
    endtask

    task automatic pulse_acr();
        acr_request = 1'b1;
        @(negedge clk_pixel);
        acr_request = 1'b0;
    endtask

    task automatic pulse_field_end();
        video_field_end = 1'b1;
        @(negedge clk_pixel);
        video_field_end = 1'b0;
    endtask

    // One slot: decision pulse, then a 32-cycle packet ending at pixel 31.
    task automatic slot();
        packet_enable = 1'b1;
        @(negedge clk_pixel);
        packet_enable = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            packet_pixel_counter = 5'(k);
            @(negedge clk_pixel);
        end
        packet_pixel_counter = 5'd0;
    endtask

    initial begin
        reset = 1'b1;
        video_field_end = 1'b0; packet_enable = 1'b0; acr_request = 1'b0;
        sample_valid = 1'b0; sample_word = '0; packet_pixel_counter = '0;
        repeat (3) @(negedge clk_pixel);
        reset = 1'b0;

        chk("rst_type",    packet_type, 8'h00);
        chk("rst_payload", sample_payload, 128'h0);
        chk("rst_present", sample_present, 4'h0);
        chk("rst_frame",   frame_counter, 8'd0);
        chk("rst_ready",   sample_ready, 1'b1);
        chk("rst_dropped", sample_dropped, 1'b0);
        chk("layout",      sample_layout, 1'b0);

        // InfoFrame order on an empty FIFO
        slot(); chk("if0", packet_type, 8'h84);
        slot(); chk("if1", packet_type, 8'h82);
        slot(); chk("if2", packet_type, 8'h83);
        slot(); chk("if_null", packet_type, 8'h00);
        pulse_field_end();
        slot(); chk("if_after_fe", packet_type, 8'h84);

        // ACR beats a full audio packet and unsent InfoFrames
        push(32'h1111_0001); push(32'h2222_0002); push(32'h3333_0003); push(32'h4444_0004);
        pulse_acr();
        pulse_field_end();
        slot(); chk("acr_first", packet_type, 8'h01);
        chk("acr_frame", frame_counter, 8'd0);
        slot(); chk("aud_type", packet_type, 8'h02);
        chk("aud_present", sample_present, 4'b1111);
        chk("aud_payload", sample_payload, {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001});
        chk("aud_cnt", dut.fifo_cnt, 3'd0);
        chk("aud_frame", frame_counter, 8'd4);

        // Run frame_counter up to 188, then wrap with one more full packet
        for (int p = 0; p < 46; p++) begin
            for (int s = 0; s < 4; s++) push(32'(p * 4 + s));
            slot();
        end
        chk("frame_188", frame_counter, 8'd188);
        push(32'hA); push(32'hB); push(32'hC); push(32'hD);
        slot();
        chk("wrap_type", packet_type, 8'h02);
        chk("frame_wrap", frame_counter, 8'd0);

        // Two residual samples
        push(32'hAAAA_0101); push(32'hBBBB_0202);
`ifdef HDMI_AUDIO_FLUSH_EN
        slot(); chk("fl_slot1", packet_type, 8'h84);
        slot(); chk("fl_slot2", packet_type, 8'h82);
        slot(); chk("fl_type", packet_type, 8'h02);
        chk("fl_present", sample_present, 4'b0011);
        chk("fl_payload", sample_payload, {64'h0, 32'hBBBB_0202, 32'hAAAA_0101});
        chk("fl_frame", frame_counter, 8'd2);
`else
        slot(); chk("res_slot1", packet_type, 8'h84);
        slot(); chk("res_slot2", packet_type, 8'h82);
        slot(); chk("res_slot3", packet_type, 8'h83);
        chk("res_cnt", dut.fifo_cnt, 3'd2);
`endif

        // Overflow on a clean FIFO
        reset = 1'b1;
        @(negedge clk_pixel);
        reset = 1'b0;
        push(32'h0A0A_0001); push(32'h0B0B_0002); push(32'h0C0C_0003);
        chk("ovf_ready3", sample_ready, 1'b1);
        push(32'h0D0D_0004);
        chk("ovf_ready4", sample_ready, 1'b0);
        chk("ovf_nodrop", sample_dropped, 1'b0);
        push(32'h0E0E_0005);
        chk("ovf_dropped", sample_dropped, 1'b1);
        slot();
        chk("ovf_payload", sample_payload, {32'h0D0D_0004, 32'h0C0C_0003, 32'h0B0B_0002, 32'h0A0A_0001});
        chk("ovf_ready_after", sample_ready, 1'b1);
        chk("ovf_sticky", sample_dropped, 1'b1);

        // Field end coinciding with a decision: Null, nothing popped
        push(32'h5555_0005); push(32'h6666_0006); push(32'h7777_0007); push(32'h8888_0008);
        packet_enable = 1'b1; video_field_end = 1'b1;
        @(negedge clk_pixel);
        packet_enable = 1'b0; video_field_end = 1'b0;
        chk("coin_type", packet_type, 8'h00);
        chk("coin_payload", sample_payload, 128'h0);
        chk("coin_cnt", dut.fifo_cnt, 3'd4);
        repeat (31) @(negedge clk_pixel);
        slot();
        chk("coin_next_payload", sample_payload, {32'h8888_0008, 32'h7777_0007, 32'h6666_0006, 32'h5555_0005});
        chk("coin_frame", frame_counter, 8'd8);

        // Asynchronous reset in the middle of a packet
        packet_enable = 1'b1;
        @(negedge clk_pixel);
        packet_enable = 1'b0;
        repeat (3) @(negedge clk_pixel);
        chk("pre_rst_type", packet_type, 8'h84);
        #2 reset = 1'b1;
        #1;
        chk("arst_type",    packet_type, 8'h00);
        chk("arst_payload", sample_payload, 128'h0);
        chk("arst_present", sample_present, 4'h0);
        chk("arst_frame",   frame_counter, 8'd0);
        chk("arst_ready",   sample_ready, 1'b1);
        chk("arst_dropped", sample_dropped, 1'b0);
        @(negedge clk_pixel);
        reset = 1'b0;
        @(negedge clk_pixel);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
